axi_rect_burst_writer: RTL and testbench
========================================

Name: axi_rect_burst_writer

Overview:
- Parametrised successor of the single-pixel-per-beat rectangle write master.
- Accepts one rectangle command and a pixel stream of 8-bit indexed colour.
- Packs pixels into full DATA_W words with per-byte strobes and writes each row as AXI3 INCR bursts to the framebuffer through an HP port.
- Splits bursts at row end, at MAX_BURST and at 4 KB boundaries.
- Tracks outstanding writes, reports errors, and signals completion only after all B responses return.

Parameters:
- DATA_W, 32, AXI data width in bits (32 or 64).
- ADDR_W, 32, AXI address width.
- MAX_BURST, 16, maximum beats per burst (1..16, AXI3 limit).
- MAX_OUTSTANDING, 4, maximum AW-accepted bursts awaiting B (1..15).
- DIM_W, 11, width of the x, y, width and height fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE when not in reset.
- cmd_base  in  ADDR_W  framebuffer base byte address.
- cmd_stride  in  16  row pitch in bytes.
- cmd_x, cmd_y  in  DIM_W  top-left pixel.
- cmd_width, cmd_height  in  DIM_W  pixel counts (0 is a legal empty rectangle).
- pixel_data  in  8  colour index.
- pixel_draw  in  1  0 means the pixel is transparent and its strobe is cleared.
- pixel_valid  in  1  pixel valid.
- pixel_ready  out  1  pixel accepted when valid and ready are both high.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky on any BRESP not equal to OKAY; cleared on the next command accept.
- M00_AXI_awaddr/awlen[3:0]/awsize/awburst/awlock[1:0]/awcache/awprot/awvalid/awready  AXI3 AW channel.
- M00_AXI_wdata[DATA_W]/wstrb[DATA_W/8]/wlast/wvalid/wready  AXI3 W channel.
- M00_AXI_bresp/bvalid/bready  AXI3 B channel.
- Read channel is not part of this block; the wrapper ties it off.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - awvalid, wvalid, wlast, done, err, busy = 0; bready = 0.
  - state = IDLE; all counters = 0.
  - Any burst in flight is abandoned; the wrapper must reset the interconnect together with this block.
- Constants:
  - awsize = log2(DATA_W/8); awburst = INCR (01); awcache = 0111; awprot = 000; awlock = 00.
  - bready = 1 whenever not in reset.
- States:
  - IDLE: cmd_ready = 1. On cmd handshake, latch the fields, set busy, clear err, go to SETUP.
  - SETUP (1 cycle): row_addr = base + y*stride + x (ADDR_W wrap). If width == 0 or height == 0, go to DRAIN; otherwise go to SEG.
  - SEG (1 cycle): compute the burst for the current row remainder (formula below).
  - DATA:
    - Assert awvalid until the AW handshake. awvalid is asserted only if outstanding < MAX_OUTSTANDING; otherwise hold.
    - Pack pixels into the word register; wvalid rises when the word's last covered lane is filled.
    - AW and W proceed independently; W may complete before AW.
    - Leave DATA only when both the AW handshake and the wlast handshake have occurred, then go to NEXT.
  - NEXT:
    - If the row has pixels left, go to SEG.
    - Else, if rows remain, row_addr += stride, decrement rows, go to SEG.
    - Else go to DRAIN.
  - DRAIN: wait until outstanding == 0, pulse done, clear busy, go to IDLE.
- Burst sizing (SEG):
  - word_addr = cur_addr with the low log2(DATA_W/8) bits cleared; lane = those low bits.
  - beats = min(MAX_BURST, ceil((lane + pixels_left)/bytes_per_word), (4096 - word_addr[11:0])/bytes_per_word).
  - awaddr = word_addr; awlen = beats - 1.
  - The segment consumes min(pixels_left, beats*bytes_per_word - lane) pixels.
- Packing:
  - Each accepted pixel writes byte lane `lane` of the word register.
  - Its strobe bit = pixel_draw.
  - Lanes outside the rectangle carry strobe 0.
  - wlast = 1 on beat index awlen.
- pixel_ready = 1 in DATA while the current word is not complete and (wvalid == 0, or wready == 1 on the final lane).
  - Sustained rate: one pixel per cycle under continuous wready.
- Outstanding counter:
  - +1 on AW handshake, -1 on B handshake; both in the same cycle leave it unchanged.
- A command while busy is not accepted.
- Pixels beyond width*height are never consumed.

Decomposition:
- Shared package axi_fb_pkg holds:
  - AXI3 encodings (BURST_INCR, RESP_OKAY, CACHE_WB_ALLOC).
  - The 4 KB boundary constant.
  - The state enum.
  - The function beats_to_boundary(addr, bytes_per_word).
- One sub-module, rect_burst_planner: combinational/registered SEG arithmetic that produces awaddr, awlen and the segment pixel count.

Test Plan (DATA_W=32, MAX_BURST=16):
1. base=0x1000_0000, stride=800, x=0, y=0, w=1, h=1, draw=1 -> AW 0x1000_0000 len0; one W beat strb=0001 wlast=1; done one cycle after bvalid.
2. x=3, y=2, w=6, h=1 -> AW 0x1000_0640 len2; strb 1000, 1111, 0001; data in matching lanes.
3. x=0, w=100, h=2 -> per row AW len15 then len8, second row at +800 (0x1000_0320); four AWs total; done after fourth B.
4. base=0x1000_0FF0, w=32, h=1 -> AW 0x1000_0FF0 len3, then AW 0x1000_1000 len3; no burst crosses 4 KB.
5. wready low 20 cycles mid-burst, awready delayed 10 cycles after wlast, pixel_draw toggling -> no pixel lost or duplicated; strobes match draw; awlen unchanged while awvalid held.
6. BRESP=SLVERR on second burst -> err=1 at done; next cmd clears err. Reset asserted mid-DATA -> awvalid=wvalid=0 and state IDLE the next cycle.

Source files
------------

// File: rtl/axi_fb_pkg.sv
// Shared AXI3 encodings, FSM state type and burst helper for the
// rectangle burst writer.
package axi_fb_pkg;

  localparam logic [1:0]  BURST_INCR     = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [3:0]  CACHE_WB_ALLOC = 4'b0111;
  localparam int unsigned BOUNDARY_4K    = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEG,
    S_DATA,
    S_NEXT,
    S_DRAIN
  } state_e;

  // Number of whole words from the word containing addr up to the next 4 KB page.
  function automatic int unsigned beats_to_boundary(input logic [11:0] addr,
                                                    input int unsigned bytes_per_word);
    int unsigned off;
    off = 32'(addr) & ~(bytes_per_word - 1);
    return (BOUNDARY_4K - off) / bytes_per_word;
  endfunction

endpackage

// File: rtl/axi_rect_burst_writer_planner.sv
// Segment planner: from the current byte address and pixels left in the row,
// produce the burst address, length and the pixel count the burst covers.
module rect_burst_planner
  import axi_fb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned DIM_W     = 11
) (
  input  logic [ADDR_W-1:0] cur_addr_i,
  input  logic [DIM_W-1:0]  pix_left_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [3:0]        awlen_o,
  output logic [DIM_W-1:0]  seg_pix_o
);
  localparam int unsigned BPW = DATA_W / 8;
  localparam int unsigned LB  = $clog2(BPW);

  logic [31:0] lane, left, need, bound, beats, cap;

  // Burst is limited by row remainder, MAX_BURST and the 4 KB page.
  always_comb begin
    lane  = 32'(cur_addr_i[LB-1:0]);
    left  = 32'(pix_left_i);
    need  = (lane + left + BPW - 1) >> LB;
    bound = beats_to_boundary(cur_addr_i[11:0], BPW);
    beats = 32'(MAX_BURST);
    if (need < beats)  beats = need;
    if (bound < beats) beats = bound;
    cap       = beats * BPW - lane;
    awaddr_o  = cur_addr_i & ~ADDR_W'(BPW - 1);
    awlen_o   = 4'(beats - 1);
    seg_pix_o = (left < cap) ? pix_left_i : DIM_W'(cap);
  end

endmodule

// File: rtl/axi_rect_burst_writer.sv
// Rectangle write master: packs an 8-bit pixel stream into DATA_W words and
// writes each row as AXI3 INCR bursts, completing after all B responses.
module axi_rect_burst_writer
  import axi_fb_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DIM_W           = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [15:0]         cmd_stride,
  input  logic [DIM_W-1:0]    cmd_x,
  input  logic [DIM_W-1:0]    cmd_y,
  input  logic [DIM_W-1:0]    cmd_width,
  input  logic [DIM_W-1:0]    cmd_height,
  input  logic [7:0]          pixel_data,
  input  logic                pixel_draw,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   M00_AXI_awaddr,
  output logic [3:0]          M00_AXI_awlen,
  output logic [2:0]          M00_AXI_awsize,
  output logic [1:0]          M00_AXI_awburst,
  output logic [1:0]          M00_AXI_awlock,
  output logic [3:0]          M00_AXI_awcache,
  output logic [2:0]          M00_AXI_awprot,
  output logic                M00_AXI_awvalid,
  input  logic                M00_AXI_awready,
  output logic [DATA_W-1:0]   M00_AXI_wdata,
  output logic [DATA_W/8-1:0] M00_AXI_wstrb,
  output logic                M00_AXI_wlast,
  output logic                M00_AXI_wvalid,
  input  logic                M00_AXI_wready,
  input  logic [1:0]          M00_AXI_bresp,
  input  logic                M00_AXI_bvalid,
  output logic                M00_AXI_bready
);
  localparam int unsigned BPW = DATA_W / 8;
  localparam int unsigned LB  = $clog2(BPW);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, row_addr_q, row_addr_d, cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [15:0]         stride_q, stride_d;
  logic [DIM_W-1:0]    x_q, x_d, y_q, y_d, width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]    pix_left_q, pix_left_d, rows_left_q, rows_left_d, seg_left_q, seg_left_d;
  logic [3:0]          awlen_q, awlen_d, beat_q, beat_d, out_q, out_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BPW-1:0]      wstrb_q, wstrb_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [ADDR_W-1:0]   plan_awaddr;
  logic [3:0]          plan_awlen;
  logic [DIM_W-1:0]    plan_seg;
  logic                aw_hs, w_hs, b_hs, pix_hs, wlast;

  rect_burst_planner #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST),
    .DIM_W     (DIM_W)
  ) u_planner (
    .cur_addr_i (cur_addr_q),
    .pix_left_i (pix_left_q),
    .awaddr_o   (plan_awaddr),
    .awlen_o    (plan_awlen),
    .seg_pix_o  (plan_seg)
  );

  assign aw_hs       = awvalid_q & M00_AXI_awready;
  assign w_hs        = wvalid_q & M00_AXI_wready;
  assign b_hs        = M00_AXI_bvalid & M00_AXI_bready;
  assign wlast       = wvalid_q && (beat_q == awlen_q);
  assign pixel_ready = (state_q == S_DATA) && (seg_left_q != '0) && (!wvalid_q || M00_AXI_wready);
  assign pix_hs      = pixel_ready & pixel_valid;

  // Next-state logic for the FSM, the AW/W channels and the word packer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    stride_d    = stride_q;
    x_d         = x_q;
    y_d         = y_q;
    width_d     = width_q;
    height_d    = height_q;
    row_addr_d  = row_addr_q;
    cur_addr_d  = cur_addr_q;
    pix_left_d  = pix_left_q;
    rows_left_d = rows_left_q;
    seg_left_d  = seg_left_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    lane_d      = lane_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    out_d       = out_q + 4'(aw_hs) - 4'(b_hs);
    if (b_hs && (M00_AXI_bresp != RESP_OKAY)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d   = cmd_base;
          stride_d = cmd_stride;
          x_d      = cmd_x;
          y_d      = cmd_y;
          width_d  = cmd_width;
          height_d = cmd_height;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        row_addr_d  = base_q + ADDR_W'(32'(y_q) * 32'(stride_q)) + ADDR_W'(x_q);
        cur_addr_d  = row_addr_d;
        pix_left_d  = width_q;
        rows_left_d = height_q - DIM_W'(1);
        state_d     = ((width_q == '0) || (height_q == '0)) ? S_DRAIN : S_SEG;
      end
      S_SEG: begin
        awaddr_d   = plan_awaddr;
        awlen_d    = plan_awlen;
        seg_left_d = plan_seg;
        lane_d     = cur_addr_q[LB-1:0];
        beat_d     = '0;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        wstrb_d    = '0;
        cur_addr_d = cur_addr_q + ADDR_W'(plan_seg);
        pix_left_d = pix_left_q - plan_seg;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (awvalid_q) begin
          if (M00_AXI_awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
        end else if (!aw_done_q && (32'(out_q) < MAX_OUTSTANDING)) begin
          awvalid_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          wstrb_d  = '0;
          beat_d   = beat_q + 4'd1;
          if (wlast) w_done_d = 1'b1;
        end
        // A pixel may land in the next word in the same cycle the current one leaves.
        if (pix_hs) begin
          wdata_d[{lane_q, 3'b000} +: 8] = pixel_data;
          wstrb_d[lane_q]                = pixel_draw;
          lane_d                         = lane_q + LB'(1);
          seg_left_d                     = seg_left_q - DIM_W'(1);
          if ((lane_q == LB'(BPW - 1)) || (seg_left_q == DIM_W'(1))) wvalid_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast))) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (pix_left_q != '0) begin
          state_d = S_SEG;
        end else if (rows_left_q != '0) begin
          row_addr_d  = row_addr_q + ADDR_W'(stride_q);
          cur_addr_d  = row_addr_d;
          pix_left_d  = width_q;
          rows_left_d = rows_left_q - DIM_W'(1);
          state_d     = S_SEG;
        end else if (out_d == '0) begin
          // Last response already back: finish without a DRAIN cycle.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      width_q     <= '0;
      height_q    <= '0;
      row_addr_q  <= '0;
      cur_addr_q  <= '0;
      pix_left_q  <= '0;
      rows_left_q <= '0;
      seg_left_q  <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      lane_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      x_q         <= x_d;
      y_q         <= y_d;
      width_q     <= width_d;
      height_q    <= height_d;
      row_addr_q  <= row_addr_d;
      cur_addr_q  <= cur_addr_d;
      pix_left_q  <= pix_left_d;
      rows_left_q <= rows_left_d;
      seg_left_q  <= seg_left_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      lane_q      <= lane_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready       = (state_q == S_IDLE) && !reset;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign M00_AXI_awaddr  = awaddr_q;
  assign M00_AXI_awlen   = awlen_q;
  assign M00_AXI_awsize  = 3'(LB);
  assign M00_AXI_awburst = BURST_INCR;
  assign M00_AXI_awlock  = 2'b00;
  assign M00_AXI_awcache = CACHE_WB_ALLOC;
  assign M00_AXI_awprot  = 3'b000;
  assign M00_AXI_awvalid = awvalid_q;
  assign M00_AXI_wdata   = wdata_q;
  assign M00_AXI_wstrb   = wstrb_q;
  assign M00_AXI_wlast   = wlast;
  assign M00_AXI_wvalid  = wvalid_q;
  assign M00_AXI_bready  = !reset;

endmodule

// File: tb/tb_axi_rect_burst_writer.sv
// Directed bench for axi_rect_burst_writer (DATA_W=32, MAX_BURST=16) with a
// small AXI slave responder and hand-computed expectations.
module tb_axi_rect_burst_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_base;
  logic [15:0] cmd_stride;
  logic [10:0] cmd_x, cmd_y, cmd_width, cmd_height;
  logic [7:0]  pixel_data;
  logic        pixel_draw, pixel_valid, pixel_ready;
  logic        busy, done, err;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axi_rect_burst_writer #(
    .DATA_W (32), .ADDR_W (32), .MAX_BURST (16), .MAX_OUTSTANDING (4), .DIM_W (11)
  ) dut (
    .clk (clk), .reset (reset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_base (cmd_base),
    .cmd_stride (cmd_stride), .cmd_x (cmd_x), .cmd_y (cmd_y),
    .cmd_width (cmd_width), .cmd_height (cmd_height),
    .pixel_data (pixel_data), .pixel_draw (pixel_draw),
    .pixel_valid (pixel_valid), .pixel_ready (pixel_ready),
    .busy (busy), .done (done), .err (err),
    .M00_AXI_awaddr (awaddr), .M00_AXI_awlen (awlen), .M00_AXI_awsize (awsize),
    .M00_AXI_awburst (awburst), .M00_AXI_awlock (awlock), .M00_AXI_awcache (awcache),
    .M00_AXI_awprot (awprot), .M00_AXI_awvalid (awvalid), .M00_AXI_awready (awready),
    .M00_AXI_wdata (wdata), .M00_AXI_wstrb (wstrb), .M00_AXI_wlast (wlast),
    .M00_AXI_wvalid (wvalid), .M00_AXI_wready (wready),
    .M00_AXI_bresp (bresp), .M00_AXI_bvalid (bvalid), .M00_AXI_bready (bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave-side capture and per-run bookkeeping
  logic [31:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  logic [31:0] w_data_q[$];
  logic [3:0]  w_strb_q[$];
  int aw_cnt, wl_cnt, b_cnt, last_b_cyc, done_cyc, acc_pix, awhold_viol;
  logic err_at_done, err_at1, busy_at1, rdy_at0, rdy_at1;
  int ws_start, ws_len, err_idx, npix;
  bit aw_wait_wl;
  logic [7:0] pix_d[256];
  logic       pix_w[256];

  task automatic set_cmd(input logic [31:0] b, input logic [15:0] s,
                         input logic [10:0] x, input logic [10:0] y,
                         input logic [10:0] w, input logic [10:0] h);
    cmd_base = b; cmd_stride = s; cmd_x = x; cmd_y = y; cmd_width = w; cmd_height = h;
    npix = int'(w) * int'(h) + 4;
    ws_start = 1000; ws_len = 0; aw_wait_wl = 0; err_idx = -1;
  endtask

  // One command from handshake to done, acting as a prompt AXI slave.
  task automatic run_cmd(input int budget);
    int cyc, wl_at;
    bit fin, pav;
    logic [31:0] paa;
    logic [3:0] pal;
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_strb_q.delete();
    aw_cnt = 0; wl_cnt = 0; b_cnt = 0; last_b_cyc = -1; done_cyc = -1;
    acc_pix = 0; awhold_viol = 0; err_at_done = 1'bx;
    cyc = 0; wl_at = -1; fin = 0; pav = 0; paa = '0; pal = '0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cmd_valid   = (cyc <= 1);
      wready      = !(cyc >= ws_start && cyc < ws_start + ws_len);
      awready     = !aw_wait_wl || (wl_at >= 0 && cyc >= wl_at + 10);
      pixel_valid = (acc_pix < npix);
      pixel_data  = pix_d[acc_pix];
      pixel_draw  = pix_w[acc_pix];
      bvalid      = (b_cnt < aw_cnt) && (b_cnt < wl_cnt);
      bresp       = (b_cnt == err_idx) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 0) rdy_at0 = cmd_ready;
      if (cyc == 1) begin rdy_at1 = cmd_ready; busy_at1 = busy; err_at1 = err; end
      if (pav && (awvalid !== 1'b1 || awaddr !== paa || awlen !== pal)) awhold_viol++;
      pav = awvalid && !awready; paa = awaddr; pal = awlen;
      if (pixel_valid && pixel_ready) acc_pix++;
      if (awvalid && awready) begin aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen); aw_cnt++; end
      if (wvalid && wready) begin
        w_data_q.push_back(wdata); w_strb_q.push_back(wstrb);
        if (wlast) begin wl_cnt++; if (wl_at < 0) wl_at = cyc; end
      end
      if (bvalid && bready) begin b_cnt++; last_b_cyc = cyc; end
      if (done) begin fin = 1; done_cyc = cyc; err_at_done = err; end
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 0; pixel_valid = 0; bvalid = 0; wready = 1; awready = 1;
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL run_timeout: no done within %0d cycles", budget); end
  endtask

  task automatic test_reset;
    reset = 1; cmd_valid = 0; pixel_valid = 0; bvalid = 0; bresp = 0;
    awready = 1; wready = 1; pixel_data = 0; pixel_draw = 0;
    set_cmd(32'h0, 16'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({awvalid, wvalid, wlast, done, err, busy, bready, cmd_ready} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000000", {awvalid, wvalid, wlast, done, err, busy, bready, cmd_ready});
    end
    @(negedge clk); reset = 0; #1;
    n_cmp++;
    if ({cmd_ready, bready} !== 2'b11) begin
      n_bad++; $display("FAIL idle_ready: got %b want 11", {cmd_ready, bready});
    end
    n_cmp++;
    if ({awsize, awburst, awlock, awcache, awprot} !== {3'd2, 2'b01, 2'b00, 4'b0111, 3'b000}) begin
      n_bad++; $display("FAIL aw_constants: got %h want %h", {awsize, awburst, awlock, awcache, awprot},
                        {3'd2, 2'b01, 2'b00, 4'b0111, 3'b000});
    end
  endtask

  task automatic test_single_pixel;
    set_cmd(32'h1000_0000, 16'd800, 11'd0, 11'd0, 11'd1, 11'd1);
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'hA5; pix_w[i] = 1'b1; end
    run_cmd(100);
    n_cmp++;
    if ({rdy_at0, rdy_at1, busy_at1} !== 3'b101) begin
      n_bad++; $display("FAIL t1_cmd_busy: got %b want 101", {rdy_at0, rdy_at1, busy_at1});
    end
    n_cmp++;
    if (aw_cnt !== 1 || w_data_q.size() !== 1) begin
      n_bad++; $display("FAIL t1_counts: aw %0d w %0d want 1 1", aw_cnt, w_data_q.size());
    end else begin
      n_cmp++;
      if (aw_addr_q[0] !== 32'h1000_0000 || aw_len_q[0] !== 4'd0 || w_strb_q[0] !== 4'b0001 || w_data_q[0][7:0] !== 8'hA5) begin
        n_bad++; $display("FAIL t1_beat: addr %h len %0d strb %b data %h want 10000000 0 0001 a5",
                          aw_addr_q[0], aw_len_q[0], w_strb_q[0], w_data_q[0][7:0]);
      end
    end
    n_cmp++;
    if (done_cyc - last_b_cyc !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t1_done_timing: got delta %0d busy %b want 1 0", done_cyc - last_b_cyc, busy);
    end
    n_cmp++;
    if (acc_pix !== 1) begin n_bad++; $display("FAIL t1_pixels: got %0d want 1", acc_pix); end
  endtask

  task automatic test_offset_row;
    logic [3:0]  es[3];
    logic [31:0] ed[3];
    logic [31:0] m;
    es[0] = 4'b1000; es[1] = 4'b1111; es[2] = 4'b0001;
    ed[0] = 32'h1100_0000; ed[1] = 32'h1514_1312; ed[2] = 32'h0000_0016;
    set_cmd(32'h1000_0000, 16'd800, 11'd3, 11'd2, 11'd6, 11'd1);
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'(8'h11 + i); pix_w[i] = 1'b1; end
    run_cmd(100);
    n_cmp++;
    if (aw_cnt !== 1 || aw_addr_q[0] !== 32'h1000_0640 || aw_len_q[0] !== 4'd2) begin
      n_bad++; $display("FAIL t2_aw: cnt %0d addr %h len %0d want 1 10000640 2", aw_cnt, aw_addr_q[0], aw_len_q[0]);
    end
    n_cmp++;
    if (w_data_q.size() !== 3) begin
      n_bad++; $display("FAIL t2_wbeats: got %0d want 3", w_data_q.size());
    end else begin
      for (int b = 0; b < 3; b++) begin
        m = '0;
        for (int l = 0; l < 4; l++) if (es[b][l]) m[8*l +: 8] = 8'hFF;
        n_cmp++;
        if (w_strb_q[b] !== es[b] || (w_data_q[b] & m) !== ed[b]) begin
          n_bad++; $display("FAIL t2_beat%0d: strb %b data %h want %b %h", b, w_strb_q[b], w_data_q[b] & m, es[b], ed[b]);
        end
      end
    end
    n_cmp++;
    if (acc_pix !== 6) begin n_bad++; $display("FAIL t2_pixels: got %0d want 6", acc_pix); end
  endtask

  task automatic test_multi_row;
    logic [31:0] ea[4];
    logic [3:0]  el[4];
    int bad_strb;
    ea[0] = 32'h1000_0000; ea[1] = 32'h1000_0040; ea[2] = 32'h1000_0320; ea[3] = 32'h1000_0360;
    el[0] = 4'd15; el[1] = 4'd8; el[2] = 4'd15; el[3] = 4'd8;
    set_cmd(32'h1000_0000, 16'd800, 11'd0, 11'd0, 11'd100, 11'd2);
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'(i); pix_w[i] = 1'b1; end
    run_cmd(1000);
    n_cmp++;
    if (aw_cnt !== 4) begin
      n_bad++; $display("FAIL t3_aw_count: got %0d want 4", aw_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (aw_addr_q[k] !== ea[k] || aw_len_q[k] !== el[k]) begin
          n_bad++; $display("FAIL t3_aw%0d: addr %h len %0d want %h %0d", k, aw_addr_q[k], aw_len_q[k], ea[k], el[k]);
        end
      end
    end
    bad_strb = 0;
    foreach (w_strb_q[i]) if (w_strb_q[i] !== 4'b1111) bad_strb++;
    n_cmp++;
    if (w_strb_q.size() !== 50 || bad_strb !== 0 || wl_cnt !== 4) begin
      n_bad++; $display("FAIL t3_wbeats: beats %0d partial %0d wlast %0d want 50 0 4", w_strb_q.size(), bad_strb, wl_cnt);
    end
    n_cmp++;
    if (b_cnt !== 4 || done_cyc - last_b_cyc !== 1 || acc_pix !== 200) begin
      n_bad++; $display("FAIL t3_done: b %0d delta %0d pix %0d want 4 1 200", b_cnt, done_cyc - last_b_cyc, acc_pix);
    end
  endtask

  task automatic test_4k_split;
    set_cmd(32'h1000_0FF0, 16'd800, 11'd0, 11'd0, 11'd32, 11'd1);
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'(i); pix_w[i] = 1'b1; end
    run_cmd(500);
    n_cmp++;
    if (aw_cnt !== 2 || w_data_q.size() !== 8) begin
      n_bad++; $display("FAIL t4_counts: aw %0d w %0d want 2 8", aw_cnt, w_data_q.size());
    end else begin
      n_cmp++;
      if (aw_addr_q[0] !== 32'h1000_0FF0 || aw_len_q[0] !== 4'd3 || aw_addr_q[1] !== 32'h1000_1000 || aw_len_q[1] !== 4'd3) begin
        n_bad++; $display("FAIL t4_aw: %h/%0d %h/%0d want 10000ff0/3 10001000/3",
                          aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
    end
  endtask

  task automatic test_stall_draw;
    logic [3:0]  es[3];
    logic [31:0] ed[3];
    logic [31:0] m;
    es[0] = 4'b1010; es[1] = 4'b1010; es[2] = 4'b0010;
    ed[0] = 32'h3200_3000; ed[1] = 32'h3600_3400; ed[2] = 32'h0000_3800;
    set_cmd(32'h1000_0000, 16'd800, 11'd1, 11'd0, 11'd10, 11'd1);
    ws_start = 5; ws_len = 20; aw_wait_wl = 1;
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'(8'h30 + i); pix_w[i] = (i % 2 == 0); end
    run_cmd(300);
    n_cmp++;
    if (aw_cnt !== 1 || aw_addr_q[0] !== 32'h1000_0000 || aw_len_q[0] !== 4'd2 || awhold_viol !== 0) begin
      n_bad++; $display("FAIL t5_aw: cnt %0d addr %h len %0d holdviol %0d want 1 10000000 2 0",
                        aw_cnt, aw_addr_q[0], aw_len_q[0], awhold_viol);
    end
    n_cmp++;
    if (w_data_q.size() !== 3 || acc_pix !== 10) begin
      n_bad++; $display("FAIL t5_counts: beats %0d pix %0d want 3 10", w_data_q.size(), acc_pix);
    end else begin
      for (int b = 0; b < 3; b++) begin
        m = '0;
        for (int l = 0; l < 4; l++) if (es[b][l]) m[8*l +: 8] = 8'hFF;
        n_cmp++;
        if (w_strb_q[b] !== es[b] || (w_data_q[b] & m) !== ed[b]) begin
          n_bad++; $display("FAIL t5_beat%0d: strb %b data %h want %b %h", b, w_strb_q[b], w_data_q[b] & m, es[b], ed[b]);
        end
      end
    end
  endtask

  task automatic test_err_clear;
    set_cmd(32'h1000_0FF0, 16'd800, 11'd0, 11'd0, 11'd32, 11'd1);
    err_idx = 1;
    for (int i = 0; i < 256; i++) begin pix_d[i] = 8'(i); pix_w[i] = 1'b1; end
    run_cmd(500);
    n_cmp++;
    if (err_at_done !== 1'b1 || err !== 1'b1) begin
      n_bad++; $display("FAIL t6_err_set: at_done %b after %b want 1 1", err_at_done, err);
    end
    set_cmd(32'h1000_0000, 16'd800, 11'd0, 11'd0, 11'd1, 11'd1);
    run_cmd(100);
    n_cmp++;
    if (err_at1 !== 1'b0 || err_at_done !== 1'b0) begin
      n_bad++; $display("FAIL t6_err_clear: at_accept %b at_done %b want 0 0", err_at1, err_at_done);
    end
  endtask

  task automatic test_reset_mid;
    set_cmd(32'h1000_0000, 16'd800, 11'd0, 11'd0, 11'd100, 11'd1);
    @(negedge clk);
    cmd_valid = 1; wready = 0; awready = 0; pixel_valid = 1; pixel_data = 8'h5A; pixel_draw = 1;
    @(negedge clk); cmd_valid = 0;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if ({awvalid, wvalid, busy} !== 3'b111) begin
      n_bad++; $display("FAIL t6_pre_reset: awvalid/wvalid/busy %b want 111", {awvalid, wvalid, busy});
    end
    @(negedge clk); reset = 1;
    @(negedge clk); #1;
    n_cmp++;
    if ({awvalid, wvalid, busy, done} !== 4'b0000) begin
      n_bad++; $display("FAIL t6_mid_reset: awvalid/wvalid/busy/done %b want 0000", {awvalid, wvalid, busy, done});
    end
    reset = 0; pixel_valid = 0; wready = 1; awready = 1;
    #1;
    n_cmp++;
    if ({cmd_ready, pixel_ready} !== 2'b10) begin
      n_bad++; $display("FAIL t6_idle_after_reset: cmd_ready/pixel_ready %b want 10", {cmd_ready, pixel_ready});
    end
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_offset_row;
    test_multi_row;
    test_4k_split;
    test_stall_draw;
    test_err_clear;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
